// File: rtl/fpu_mem_stage.sv
// Memory/writeback stage after the FPU execute stage: forwards results or performs
// flw/fsw through a valid/ready request channel, retiring each op with a one-cycle pulse.
module fpu_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_result,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        wb_valid,
  output logic        wb_fwrite,
  output logic        wb_iwrite,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_misaligned
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  logic [1:0]  state;
  logic [1:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        wb_mis_q;
  logic        mis_in;

  assign mis_in = in_op[1] && (in_result[1:0] != 2'b00);

  // wb_* registers are loaded only on entry to WB so they hold between retirements
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rd_q      <= 5'd0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
      wb_mis_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q    <= in_op;
            addr_q  <= in_result;
            wdata_q <= (in_op == 2'd3) ? in_store_data : 32'd0;
            rd_q    <= in_rd;
            if (in_op[1] && !mis_in) begin
              state <= ST_REQ;
            end else begin
              wb_rd_q   <= in_rd;
              wb_data_q <= in_result;
              wb_mis_q  <= mis_in;
              state     <= ST_WB;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            if (op_q[0]) begin
              wb_rd_q  <= rd_q;
              wb_mis_q <= 1'b0;
              state    <= ST_WB;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (mem_resp_valid) begin
            wb_rd_q   <= rd_q;
            wb_data_q <= mem_resp_data;
            wb_mis_q  <= 1'b0;
            state     <= ST_WB;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = (state == ST_IDLE) && !rst;
  assign mem_req_valid = (state == ST_REQ);
  assign mem_req_we    = (op_q == 2'd3);
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;

  assign wb_valid      = (state == ST_WB);
  assign wb_fwrite     = wb_valid && (op_q == 2'd0 || op_q == 2'd2) && !wb_mis_q;
  assign wb_iwrite     = wb_valid && (op_q == 2'd1) && (wb_rd_q != 5'd0);
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign wb_misaligned = wb_mis_q;

endmodule

// File: tb/tb_fpu_mem_stage.sv
// Self-checking bench for fpu_mem_stage: directed plan cases plus randomized
// instructions checked against expectations derived from the op semantics.
module tb_fpu_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [31:0] in_result = 32'd0;
  logic [31:0] in_store_data = 32'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'd0;
  logic        wb_valid;
  logic        wb_fwrite;
  logic        wb_iwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_misaligned;

  int n_cmp = 0;
  int n_err = 0;

  fpu_mem_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_result(in_result), .in_store_data(in_store_data), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .wb_valid(wb_valid), .wb_fwrite(wb_fwrite), .wb_iwrite(wb_iwrite),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_misaligned(wb_misaligned)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one instruction and checks the full transaction; starts and ends 1 ns after an edge.
  task automatic run_instr(input logic [1:0] op, input logic [31:0] res, input logic [31:0] sd,
                           input logic [4:0] rd, input int rdly, input int resp_dly,
                           input logic [31:0] rdata, input logic noise);
    logic mis, exp_f, exp_i, is_mem;
    mis    = op[1] && (res[1:0] != 2'b00);
    is_mem = op[1] && !mis;
    exp_f  = (op == 2'd0 || op == 2'd2) && !mis;
    exp_i  = (op == 2'd1) && (rd != 5'd0);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL accept_ready: got %b want 1", in_ready); end
    in_valid = 1'b1; in_op = op; in_result = res; in_store_data = sd; in_rd = rd;
    step();
    in_valid = 1'b0; in_op = 2'($urandom); in_result = $urandom;
    in_store_data = $urandom; in_rd = 5'($urandom);
    if (is_mem) begin
      for (int d = 0; d <= rdly; d++) begin
        n_cmp++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== res || mem_req_we !== op[0] ||
            mem_req_wdata !== (op[0] ? sd : 32'd0) || wb_valid !== 1'b0) begin
          n_err++;
          $display("FAIL req_hold: got v=%b a=%h we=%b wd=%h wbv=%b want v=1 a=%h we=%b wd=%h wbv=0",
                   mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, wb_valid,
                   res, op[0], op[0] ? sd : 32'd0);
        end
        mem_req_ready  = (d == rdly);
        mem_resp_valid = noise ? 1'($urandom) : 1'b0;
        mem_resp_data  = $urandom;
        step();
      end
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      n_cmp++;
      if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL req_drop: got %b want 0", mem_req_valid); end
      if (op == 2'd2) begin
        for (int d = 0; d < resp_dly; d++) begin
          n_cmp++;
          if (wb_valid !== 1'b0) begin n_err++; $display("FAIL resp_wait: wb_valid got %b want 0", wb_valid); end
          step();
        end
        mem_resp_valid = 1'b1; mem_resp_data = rdata;
        step();
        mem_resp_valid = 1'b0; mem_resp_data = $urandom;
      end
    end else begin
      n_cmp++;
      if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL no_req: got %b want 0", mem_req_valid); end
    end
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_fwrite !== exp_f || wb_iwrite !== exp_i ||
        wb_rd !== rd || wb_misaligned !== mis) begin
      n_err++;
      $display("FAIL wb_ctrl op=%0d: got v=%b f=%b i=%b rd=%0d mis=%b want v=1 f=%b i=%b rd=%0d mis=%b",
               op, wb_valid, wb_fwrite, wb_iwrite, wb_rd, wb_misaligned, exp_f, exp_i, rd, mis);
    end
    if (!mis && op != 2'd3) begin
      n_cmp++;
      if (wb_data !== ((op == 2'd2) ? rdata : res)) begin
        n_err++;
        $display("FAIL wb_data op=%0d: got %h want %h", op, wb_data, (op == 2'd2) ? rdata : res);
      end
    end
    step();
    n_cmp++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL wb_once: got wb_valid=%b in_ready=%b want 0/1", wb_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_cmp++;
    if ({in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, wb_valid,
         wb_fwrite, wb_iwrite, wb_rd, wb_data, wb_misaligned} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b wbv=%b addr=%h wbd=%h want all 0",
               in_ready, mem_req_valid, wb_valid, mem_req_addr, wb_data);
    end
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release: in_ready got %b want 1", in_ready); end
    step();
  endtask

  task automatic test_plan();
    run_instr(2'd0, 32'h3F800000, 32'd0, 5'd5, 0, 0, 32'd0, 1'b0);
    run_instr(2'd1, 32'd1, 32'd0, 5'd0, 0, 0, 32'd0, 1'b0);
    run_instr(2'd1, 32'd1, 32'd0, 5'd3, 0, 0, 32'd0, 1'b0);
    run_instr(2'd2, 32'h100, 32'd0, 5'd2, 3, 1, 32'h40490FDB, 1'b0);
    run_instr(2'd3, 32'h204, 32'hC0000000, 5'd7, 0, 0, 32'd0, 1'b0);
    run_instr(2'd2, 32'h102, 32'd0, 5'd4, 0, 0, 32'd0, 1'b0);
    run_instr(2'd2, 32'h80, 32'd0, 5'd0, 0, 0, 32'h12345678, 1'b0);
  endtask

  task automatic test_reset_mid();
    // reset while a request is stalled: the request must drop without a clock edge
    in_valid = 1'b1; in_op = 2'd3; in_result = 32'h40; in_store_data = 32'hAA; in_rd = 5'd1;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL mid_req: got %b want 1", mem_req_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (mem_req_valid !== 1'b0 || in_ready !== 1'b0 || wb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_drop: got rv=%b rdy=%b wbv=%b want 0/0/0", mem_req_valid, in_ready, wb_valid);
    end
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_release: in_ready got %b want 1", in_ready); end
    step();
    // reset while waiting for a load response, then a late response arrives
    in_valid = 1'b1; in_op = 2'd2; in_result = 32'h300; in_rd = 5'd9;
    step();
    in_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL resp_release: in_ready got %b want 1", in_ready); end
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF;
    step();
    mem_resp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (wb_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
        n_err++;
        $display("FAIL late_resp: got wbv=%b rv=%b want 0/0", wb_valid, mem_req_valid);
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  op;
      logic [31:0] res;
      op  = 2'($urandom);
      res = $urandom;
      if ($urandom_range(0, 2) != 0) res[1:0] = 2'b00;
      run_instr(op, res, $urandom, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 2), $urandom, 1'b1);
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++)
      run_instr(2'(n % 2), $urandom, 32'd0, 5'(n + 1), 0, 0, 32'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_plan();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_mem_stage.md
# fpu_mem_stage

Memory/writeback stage directly downstream of the combinational FPU execute stage. It accepts one FPU result per transaction and either forwards it to writeback (arithmetic, compare, convert, move) or uses it as the effective address of an `flw`/`fsw` data-memory access. Memory access uses a valid/ready request channel and a valid-only response channel. Each instruction retires as a single-cycle writeback pulse. The stage holds at most one instruction and stalls the FPU via `in_ready` while busy.

## Interface
Parameters:
- None. Data and address widths are fixed at 32. Register index width is fixed at 5.

Ports:
- `clk`  in  1  sole clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  FPU result and control valid this cycle
- `in_ready`  out  1  stage can accept; equals (state==IDLE) && !rst
- `in_op`  in  2  0=float reg write, 1=int reg write, 2=flw, 3=fsw
- `in_result`  in  32  FPU result; for op 2/3 this is the byte address
- `in_store_data`  in  32  fsw data (frs2), used only for op 3
- `in_rd`  in  5  destination register index
- `mem_req_valid`  out  1  memory request pending
- `mem_req_ready`  in  1  memory accepts request this cycle
- `mem_req_we`  out  1  1=store, 0=load
- `mem_req_addr`  out  32  byte address, word aligned
- `mem_req_wdata`  out  32  store data
- `mem_resp_valid`  in  1  load data valid this cycle
- `mem_resp_data`  in  32  load data
- `wb_valid`  out  1  one-cycle retire pulse
- `wb_fwrite`  out  1  write `wb_data` to float reg `wb_rd`
- `wb_iwrite`  out  1  write `wb_data` to int reg `wb_rd`
- `wb_rd`  out  5  destination index
- `wb_data`  out  32  writeback value
- `wb_misaligned`  out  1  retiring op was an flw/fsw with addr[1:0]!=0

## Operation
- The FSM has four states: IDLE, REQ, RESP and WB. All outputs are registered or decoded from the state and registers only.
- In IDLE, the stage latches op, result, store_data and rd when `in_valid` is high, since `in_ready` is 1.
  - Op 0 or 1 goes to WB with `wb_data` = `in_result`.
  - Op 2 or 3 with `in_result[1:0]` = 0 goes to REQ.
  - Op 2 or 3 with `in_result[1:0]` != 0 goes to WB with `wb_misaligned` = 1. No memory request is issued and no register write occurs.
- In REQ, `mem_req_valid` is 1. We, addr and wdata are held stable until `mem_req_ready` is 1.
  - On handshake, a load goes to RESP.
  - On handshake, a store goes to WB with both write enables at 0.
- In RESP, the stage waits indefinitely for `mem_resp_valid`. It captures `mem_resp_data` into `wb_data` and goes to WB. A response in any other state is ignored.
- In WB, `wb_valid` is 1 for exactly one cycle, then the FSM returns to IDLE.
  - `wb_fwrite` = `wb_valid` & (op==0 | op==2) & !misaligned.
  - `wb_iwrite` = `wb_valid` & op==1 & (rd!=0). Integer x0 is never written; float f0 is writable.
- `wb_rd`, `wb_data` and `wb_misaligned` hold their values until the next WB. They are only meaningful while `wb_valid` is 1.
- `mem_req_wdata` is 0 for loads.

## Timing
- Reset value of every output is 0, and the state is IDLE. `in_ready` is 0 while `rst` is high and 1 in the first cycle after deassertion.
- Reset mid-operation abandons the instruction immediately.
  - `mem_req_valid` drops asynchronously.
  - No `wb_valid` is produced for the abandoned instruction.
  - A late `mem_resp_valid` arriving after reset is ignored.
- Latency from the accept edge t:
  - Op 0/1 and misaligned ops: `wb_valid` at t+1.
  - Store with `mem_req_ready` high immediately: request at t+1, `wb_valid` at t+2.
  - Load with `mem_req_ready` high immediately and response one cycle later: request at t+1, response at t+2, `wb_valid` at t+3.
- The response is never sampled in the same cycle as the request handshake.
- Throughput: op 0/1 can sustain one instruction every 2 cycles, because `in_ready` is 0 in WB.
- A `mem_req_ready` that stays low keeps the stage in REQ with stable outputs. Requests are never withdrawn.

## Test plan
- Reset, then `in_valid` with op=0, rd=5, result=0x3F800000 → at t+1: `wb_valid`=1, `wb_fwrite`=1, `wb_rd`=5, `wb_data`=0x3F800000. Next cycle: `wb_valid`=0 and `in_ready`=1.
- Op=1, rd=0, result=1 → `wb_valid`=1 with `wb_iwrite`=0. Repeat with rd=3 → `wb_iwrite`=1, `wb_data`=1.
- flw at addr 0x100, rd=2; memory holds `mem_req_ready` low for 3 cycles, then responds 0x40490FDB two cycles after the handshake → `mem_req_valid`, addr 0x100 and we=0 are stable throughout the stall. `wb_fwrite`=1 with `wb_data`=0x40490FDB, exactly once.
- fsw at addr 0x204 with data 0xC0000000 and immediate ready → at t+1: `mem_req_we`=1, wdata=0xC0000000. At t+2: `wb_valid`=1, with `wb_fwrite`=0 and `wb_iwrite`=0.
- flw at addr 0x102 → no `mem_req_valid` ever. At t+1: `wb_valid`=1, `wb_misaligned`=1, `wb_fwrite`=0.
- Assert `rst` while in RESP, then pulse `mem_resp_valid` after deassertion → no `wb_valid` is produced, and `in_ready`=1 right after reset deasserts.
